// File: rtl/free_list.sv
// free_list: physical-register free list for register renaming.
//
// A circular array holds free physical register indices. Rename pops
// entries from the speculative head. Commit pushes the retired
// destination's previous mapping at the tail and advances the
// architectural head. A flush rewinds the speculative head to the
// architectural head, so every speculative allocation becomes free again.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alloc_req_i         rename wants one free register this cycle
//   alloc_gnt_o         request granted; alloc_preg_o is consumed
//   alloc_preg_o        register at the speculative head
//   empty_o             no free register available
//   commit_valid_i      ROB retired an instruction
//   commit_has_rd_i     retired instruction wrote a destination
//   commit_old_preg_i   previous mapping, returned to the list
//   flush_i             discard all speculative allocations
//   free_count_o        registered number of free entries
//   overflow_o          sticky: release attempted while list full
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int FL_DEPTH  = NUM_PREGS - NUM_ARCH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [PREG_W-1:0]          alloc_preg_o,
  output logic                       empty_o,
  input  logic                       commit_valid_i,
  input  logic                       commit_has_rd_i,
  input  logic [PREG_W-1:0]          commit_old_preg_i,
  input  logic                       flush_i,
  output logic [$clog2(FL_DEPTH):0]  free_count_o,
  output logic                       overflow_o
);

  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CNT_W = $clog2(FL_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FL_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FL_DEPTH - 1);

  logic [PREG_W-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0]  spec_head;
  logic [PTR_W-1:0]  arch_head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              release_req;
  logic              release_ok;
  logic              overflow_evt;
  logic [PTR_W-1:0]  arch_head_nxt;

  // Modulo-FL_DEPTH increment so non-power-of-two depths also wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o      = (count == '0);
  assign alloc_preg_o = mem[spec_head];
  assign alloc_gnt_o  = alloc_req_i && !empty_o && !flush_i;
  assign free_count_o = count;

  assign release_req  = commit_valid_i && commit_has_rd_i;
  // A full list can still accept a release if a grant frees a slot this cycle.
  assign overflow_evt = release_req && (count == FULL_CNT) && !alloc_gnt_o;
  assign release_ok   = release_req && !overflow_evt;

  // Flush rewinds to the architectural head including this cycle's commit.
  assign arch_head_nxt = release_ok ? ptr_inc(arch_head) : arch_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_W'(NUM_ARCH + i);
      end
      spec_head  <= '0;
      arch_head  <= '0;
      tail       <= '0;
      count      <= FULL_CNT;
      overflow_o <= 1'b0;
    end else begin
      if (release_ok) begin
        mem[tail] <= commit_old_preg_i;
        tail      <= ptr_inc(tail);
      end
      arch_head <= arch_head_nxt;

      if (flush_i) begin
        spec_head <= arch_head_nxt;
      end else if (alloc_gnt_o) begin
        spec_head <= ptr_inc(spec_head);
      end

      // The committed free count is always FL_DEPTH, so a flush restores it.
      if (flush_i) begin
        count <= FULL_CNT;
      end else if (alloc_gnt_o && !release_ok) begin
        count <= count - CNT_W'(1);
      end else if (release_ok && !alloc_gnt_o) begin
        count <= count + CNT_W'(1);
      end

      if (overflow_evt) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: self-checking bench for free_list.
// A vector table covers basic behaviour from reset; hand-written sequences
// cover the multi-cycle corners; a random phase compares every cycle
// against a queue-based model of free and in-flight registers.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req_i = 1'b0;
  logic       alloc_gnt_o;
  logic [5:0] alloc_preg_o;
  logic       empty_o;
  logic       commit_valid_i = 1'b0;
  logic       commit_has_rd_i = 1'b0;
  logic [5:0] commit_old_preg_i = '0;
  logic       flush_i = 1'b0;
  logic [5:0] free_count_o;
  logic       overflow_o;

  int checks = 0;
  int failures = 0;

  // Model: free registers in allocation order, and speculatively allocated
  // registers in allocation order (oldest first).
  int free_q[$];
  int infl_q[$];
  bit mdl_ovf;

  logic       last_gnt, last_empty, last_ovf;
  logic [5:0] last_preg, last_cnt;

  free_list dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_preg_o(alloc_preg_o), .empty_o(empty_o),
    .commit_valid_i(commit_valid_i), .commit_has_rd_i(commit_has_rd_i),
    .commit_old_preg_i(commit_old_preg_i), .flush_i(flush_i),
    .free_count_o(free_count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    mdl_ovf = 1'b0;
  endtask

  // One clock cycle: apply inputs after the falling edge, sample and compare
  // against the model, then advance the model on the rising edge.
  task automatic drive(input logic r, input logic req, input logic cv, input logic hr,
                       input logic [5:0] old, input logic fl);
    bit g, rel;
    @(negedge clk);
    rst = r; alloc_req_i = req; commit_valid_i = cv; commit_has_rd_i = hr;
    commit_old_preg_i = old; flush_i = fl;
    #1;
    last_gnt = alloc_gnt_o; last_preg = alloc_preg_o; last_empty = empty_o;
    last_cnt = free_count_o; last_ovf = overflow_o;
    g = req && (free_q.size() > 0) && !fl;
    if (!r) begin
      chk("mdl_gnt", {31'd0, last_gnt}, {31'd0, g});
      chk("mdl_cnt", {26'd0, last_cnt}, free_q.size());
      chk("mdl_empty", {31'd0, last_empty}, {31'd0, free_q.size() == 0});
      chk("mdl_ovf", {31'd0, last_ovf}, {31'd0, mdl_ovf});
      if (free_q.size() > 0) chk("mdl_preg", {26'd0, last_preg}, free_q[0]);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      rel = cv && hr;
      if (g) infl_q.push_back(free_q.pop_front());
      if (rel) begin
        if (free_q.size() == 32) begin
          mdl_ovf = 1'b1;
        end else begin
          free_q.push_back(old);
          if (infl_q.size() > 0) void'(infl_q.pop_front());
        end
      end
      if (fl) begin
        while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
      end
    end
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 6'd0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 6'd0, 0);
  endtask

  typedef struct packed {
    logic       req;
    logic       cv;
    logic       hr;
    logic [5:0] old;
    logic       fl;
    logic       e_gnt;
    logic [5:0] e_preg;
    logic [5:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{req:0, cv:0, hr:0, old:0,  fl:0, e_gnt:0, e_preg:32, e_cnt:32, e_ovf:0};
    vt[1]  = '{req:1, cv:0, hr:0, old:0,  fl:0, e_gnt:1, e_preg:32, e_cnt:32, e_ovf:0};
    vt[2]  = '{req:1, cv:0, hr:0, old:0,  fl:0, e_gnt:1, e_preg:33, e_cnt:31, e_ovf:0};
    vt[3]  = '{req:1, cv:0, hr:0, old:0,  fl:1, e_gnt:0, e_preg:34, e_cnt:30, e_ovf:0};
    vt[4]  = '{req:0, cv:0, hr:0, old:0,  fl:0, e_gnt:0, e_preg:32, e_cnt:32, e_ovf:0};
    vt[5]  = '{req:1, cv:1, hr:0, old:3,  fl:0, e_gnt:1, e_preg:32, e_cnt:32, e_ovf:0};
    vt[6]  = '{req:0, cv:1, hr:1, old:7,  fl:0, e_gnt:0, e_preg:33, e_cnt:31, e_ovf:0};
    vt[7]  = '{req:0, cv:1, hr:1, old:9,  fl:0, e_gnt:0, e_preg:33, e_cnt:32, e_ovf:0};
    vt[8]  = '{req:0, cv:0, hr:0, old:0,  fl:0, e_gnt:0, e_preg:33, e_cnt:32, e_ovf:1};
    vt[9]  = '{req:1, cv:1, hr:1, old:10, fl:0, e_gnt:1, e_preg:33, e_cnt:32, e_ovf:1};
    vt[10] = '{req:0, cv:0, hr:0, old:0,  fl:0, e_gnt:0, e_preg:34, e_cnt:32, e_ovf:1};

    model_reset();

    // Reset state.
    do_reset();
    chk("rst_empty", {31'd0, empty_o}, 0);
    chk("rst_preg", {26'd0, alloc_preg_o}, 32);
    chk("rst_cnt", {26'd0, free_count_o}, 32);
    chk("rst_ovf", {31'd0, overflow_o}, 0);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      drive(0, vt[i].req, vt[i].cv, vt[i].hr, vt[i].old, vt[i].fl);
      chk($sformatf("vec%0d_gnt", i), {31'd0, last_gnt}, {31'd0, vt[i].e_gnt});
      chk($sformatf("vec%0d_preg", i), {26'd0, last_preg}, {26'd0, vt[i].e_preg});
      chk($sformatf("vec%0d_cnt", i), {26'd0, last_cnt}, {26'd0, vt[i].e_cnt});
      chk($sformatf("vec%0d_ovf", i), {31'd0, last_ovf}, {31'd0, vt[i].e_ovf});
    end

    // Drain: 32 grants in order, then empty.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, 0, 6'd0, 0);
      chk("drain_gnt", {31'd0, last_gnt}, 1);
      chk("drain_preg", {26'd0, last_preg}, 32 + i);
    end
    drive(0, 1, 0, 0, 6'd0, 0);
    chk("empty_flag", {31'd0, last_empty}, 1);
    chk("empty_gnt", {31'd0, last_gnt}, 0);
    chk("empty_cnt", {26'd0, last_cnt}, 0);

    // Release into empty list: no bypass, allocatable next cycle.
    drive(0, 1, 1, 1, 6'd5, 0);
    chk("nobypass_gnt", {31'd0, last_gnt}, 0);
    drive(0, 1, 0, 0, 6'd0, 0);
    chk("rel5_gnt", {31'd0, last_gnt}, 1);
    chk("rel5_preg", {26'd0, last_preg}, 5);
    chk("rel5_cnt_after", {26'd0, free_count_o}, 0);

    // Allocate three then flush.
    do_reset();
    repeat (3) drive(0, 1, 0, 0, 6'd0, 0);
    drive(0, 1, 0, 0, 6'd0, 1);
    chk("flush_gnt", {31'd0, last_gnt}, 0);
    chk("flush_preg", {26'd0, alloc_preg_o}, 32);
    chk("flush_cnt", {26'd0, free_count_o}, 32);

    // Commit survives a flush; slot 0 holds the returned register.
    do_reset();
    drive(0, 1, 0, 0, 6'd0, 0);
    drive(0, 0, 1, 1, 6'd7, 0);
    drive(0, 1, 0, 0, 6'd0, 0);
    drive(0, 0, 0, 0, 6'd0, 1);
    chk("cflush_preg", {26'd0, alloc_preg_o}, 33);
    chk("cflush_cnt", {26'd0, free_count_o}, 32);
    repeat (31) drive(0, 1, 0, 0, 6'd0, 0);
    chk("slot0_preg", {26'd0, alloc_preg_o}, 7);

    // Overflow on full list, sticky; none when a grant frees a slot.
    do_reset();
    drive(0, 0, 1, 1, 6'd9, 0);
    chk("ovf_set", {31'd0, overflow_o}, 1);
    chk("ovf_cnt", {26'd0, free_count_o}, 32);
    repeat (3) idle();
    chk("ovf_sticky", {31'd0, overflow_o}, 1);
    do_reset();
    drive(0, 1, 1, 1, 6'd9, 0);
    chk("noovf_gnt", {31'd0, last_gnt}, 1);
    chk("noovf_flag", {31'd0, overflow_o}, 0);
    chk("noovf_cnt", {26'd0, free_count_o}, 32);

    // 40 alloc/release pairs across the wrap point.
    do_reset();
    repeat (5) drive(0, 1, 0, 0, 6'd0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 1, 1, 6'((i * 7 + 3) % 64), 0);
      chk("pair_cnt", {26'd0, free_count_o}, 27);
      chk("pair_ovf", {31'd0, overflow_o}, 0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 9) < 8),
            6'($urandom_range(0, 63)),
            ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
